sw_debounce_scheduler: RTL and testbench

- Debounces N_CH raw switch inputs using one shared prescaler and one shared compare/update datapath.
- A round-robin scheduler services one channel per clock in a sweep that starts on each prescaler tick.
- Produces debounced levels plus one-cycle press/release pulses for downstream button logic.
- Sits between board switch pins and the control FSMs; clocked from the 125 MHz board clock.

---
 rtl/sw_debounce_scheduler.sv | 148 ++++++++++++++
 tb/tb_sw_debounce_scheduler.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce_scheduler.sv
// Time-multiplexed switch debouncer: one prescaler, one compare/update
// datapath, and a round-robin sweep that services one channel per clock.
//
// Ports:
//   clk       : system clock
//   i_rst     : synchronous active-high reset
//   i_en      : scheduler enable (prescaler runs, sweeps may start)
//   i_switch  : raw asynchronous switch levels, N_CH bits
//   o_switch  : debounced levels
//   o_press   : one-cycle pulse on a debounced 0->1 transition
//   o_release : one-cycle pulse on a debounced 1->0 transition
//   o_busy    : high while a sweep is in progress
module sw_debounce_scheduler #(
    parameter int N_CH       = 4,
    parameter int TICK_DIV   = 1250,
    parameter int STABLE_CNT = 500
) (
    input  logic            clk,
    input  logic            i_rst,
    input  logic            i_en,
    input  logic [N_CH-1:0] i_switch,
    output logic [N_CH-1:0] o_switch,
    output logic [N_CH-1:0] o_press,
    output logic [N_CH-1:0] o_release,
    output logic            o_busy
);

    localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CNT_W = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    // A sweep must finish before the next tick, otherwise slots overlap.
    generate
        if (TICK_DIV <= N_CH + 1) begin : g_bad_div
            $error("TICK_DIV must be greater than N_CH+1");
        end
    endgenerate

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [PTR_W-1:0]  ptr;
    logic [PTR_W-1:0]  ptr_nxt;
    logic              svc;
    logic              tick;
    logic [PW-1:0]     presc;
    logic [N_CH-1:0]   sync_a;
    logic [N_CH-1:0]   sync;
    logic [CNT_W-1:0]  cnt [N_CH];
    logic              cur_sync;
    logic              cur_lvl;
    logic [CNT_W-1:0]  cur_cnt;

    // Two-flop synchronizer; only the second stage is ever compared.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            sync_a <= '0;
            sync   <= '0;
        end else begin
            sync_a <= i_switch;
            sync   <= sync_a;
        end
    end

    // Disabling parks the prescaler at 0 so a re-enable starts a full period.
    assign tick = i_en && (presc == PW'(TICK_DIV - 1));

    always_ff @(posedge clk) begin
        if (i_rst || !i_en) begin
            presc <= '0;
        end else if (tick) begin
            presc <= '0;
        end else begin
            presc <= presc + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // A running sweep ignores i_en so every channel gets its slot.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        svc       = 1'b0;
        o_busy    = 1'b0;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    ptr_nxt   = '0;
                    state_nxt = SWEEP;
                end
            end
            SWEEP: begin
                o_busy = 1'b1;
                svc    = 1'b1;
                if (ptr == PTR_W'(N_CH - 1)) begin
                    state_nxt = IDLE;
                end else begin
                    ptr_nxt = ptr + PTR_W'(1);
                end
            end
        endcase
    end

    assign cur_sync = sync[ptr];
    assign cur_lvl  = o_switch[ptr];
    assign cur_cnt  = cnt[ptr];

    // Shared compare/update path: any agreeing slot restarts the count.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            o_switch  <= '0;
            o_press   <= '0;
            o_release <= '0;
            for (int k = 0; k < N_CH; k++) begin
                cnt[k] <= '0;
            end
        end else begin
            o_press   <= '0;
            o_release <= '0;
            if (svc) begin
                if (cur_sync == cur_lvl) begin
                    cnt[ptr] <= '0;
                end else if (cur_cnt == CNT_W'(STABLE_CNT - 1)) begin
                    cnt[ptr]       <= '0;
                    o_switch[ptr]  <= cur_sync;
                    o_press[ptr]   <= cur_sync;
                    o_release[ptr] <= !cur_sync;
                end else begin
                    cnt[ptr] <= cur_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sw_debounce_scheduler.sv
// Randomized bench for sw_debounce_scheduler against a slot-based
// reference model computed from sweep timing and mismatch counts.
module tb_sw_debounce_scheduler;

    localparam int N  = 4;
    localparam int TD = 8;
    localparam int SC = 4;

    logic         clk = 1'b0;
    logic         i_rst;
    logic         i_en;
    logic [N-1:0] i_switch;
    logic [N-1:0] o_switch;
    logic [N-1:0] o_press;
    logic [N-1:0] o_release;
    logic         o_busy;

    always #5 clk = ~clk;

    sw_debounce_scheduler #(
        .N_CH      (N),
        .TICK_DIV  (TD),
        .STABLE_CNT(SC)
    ) dut (
        .clk      (clk),
        .i_rst    (i_rst),
        .i_en     (i_en),
        .i_switch (i_switch),
        .o_switch (o_switch),
        .o_press  (o_press),
        .o_release(o_release),
        .o_busy   (o_busy)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d exp %0d", tag, got, exp);
        end
    endtask

    // Reference model: pins pass through a 2-edge delay; a tick at edge e
    // gives channel k a service slot at edge e+k+1; a channel's level flips
    // on the SC-th consecutive mismatching slot.
    logic [N-1:0] m_d1, m_d2, m_lvl, m_press, m_rel;
    int           m_cnt [N];
    int           run;
    int           sweep_t;
    int           edge_n;
    int           cyc;

    task automatic model_edge();
        int k;
        edge_n++;
        if (i_rst) begin
            m_d1 = '0; m_d2 = '0; m_lvl = '0;
            m_press = '0; m_rel = '0;
            for (int j = 0; j < N; j++) m_cnt[j] = 0;
            run = 0;
            sweep_t = -1000;
            return;
        end
        m_press = '0;
        m_rel = '0;
        k = edge_n - sweep_t - 1;
        if (k >= 0 && k < N) begin
            if (m_d2[k] == m_lvl[k]) begin
                m_cnt[k] = 0;
            end else begin
                m_cnt[k]++;
                if (m_cnt[k] == SC) begin
                    m_cnt[k] = 0;
                    m_lvl[k] = m_d2[k];
                    if (m_d2[k]) m_press[k] = 1'b1;
                    else m_rel[k] = 1'b1;
                end
            end
        end
        if (i_en && (run % TD == TD - 1)) sweep_t = edge_n;
        run = i_en ? run + 1 : 0;
        m_d2 = m_d1;
        m_d1 = i_switch;
    endtask

    function automatic int m_busy();
        return (edge_n - sweep_t >= 0 && edge_n - sweep_t < N) ? 1 : 0;
    endfunction

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc++;
        chk("o_switch", int'(o_switch), int'(m_lvl));
        chk("o_press", int'(o_press), int'(m_press));
        chk("o_release", int'(o_release), int'(m_rel));
        chk("o_busy", int'(o_busy), m_busy());
        chk("press_and_release", int'(o_press & o_release), 0);
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int first_busy;
    int busy_cnt;
    int npulse;
    int p1_cyc;
    int p3_cyc;
    int budget;

    initial begin
        edge_n = 0;
        cyc = 0;
        run = 0;
        sweep_t = -1000;
        m_d1 = '0; m_d2 = '0; m_lvl = '0;
        m_press = '0; m_rel = '0;
        for (int j = 0; j < N; j++) m_cnt[j] = 0;

        // Reset with all pins high
        i_rst = 1'b1;
        i_en = 1'b1;
        i_switch = 4'hF;
        run_n(3);
        chk("reset_outs", int'({o_switch, o_press, o_release, o_busy}), 0);

        // Release: first tick 8 edges later, 4 busy cycles per period
        @(negedge clk);
        i_rst = 1'b0;
        i_switch = 4'h0;
        first_busy = -1;
        for (int i = 1; i <= 12; i++) begin
            cycle();
            if (o_busy && first_busy < 0) first_busy = i;
        end
        chk("first_tick", first_busy, TD);
        busy_cnt = 0;
        for (int i = 0; i < TD; i++) begin
            cycle();
            if (o_busy) busy_cnt++;
        end
        chk("busy_per_period", busy_cnt, N);

        // Clean press on ch0
        i_switch[0] = 1'b1;
        npulse = 0;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (o_press[0]) npulse++;
        end
        chk("ch0_press_count", npulse, 1);
        chk("ch0_level", int'(o_switch[0]), 1);

        // Bounce on ch2
        i_switch[2] = 1'b1;
        run_n(3 * TD);
        i_switch[2] = 1'b0;
        run_n(TD);
        i_switch[2] = 1'b1;
        run_n(60);
        chk("ch2_level", int'(o_switch[2]), 1);

        // Simultaneous press on ch1 and ch3
        i_switch[1] = 1'b1;
        i_switch[3] = 1'b1;
        p1_cyc = -1000;
        p3_cyc = -2000;
        for (int i = 0; i < 70; i++) begin
            cycle();
            if (o_press[1]) p1_cyc = cyc;
            if (o_press[3]) p3_cyc = cyc;
        end
        chk("ch1_ch3_gap", p3_cyc - p1_cyc, 2);

        // Release with the enable dropped mid-count
        i_switch[0] = 1'b0;
        npulse = 0;
        run_n(20);
        i_en = 1'b0;
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            cycle();
            if (o_busy) busy_cnt++;
            if (o_release[0]) npulse++;
        end
        chk("disabled_level", int'(o_switch[0]), 1);
        chk("disabled_busy_le", (busy_cnt <= N) ? 1 : 0, 1);
        i_en = 1'b1;
        for (int i = 0; i < 60; i++) begin
            cycle();
            if (o_release[0]) npulse++;
        end
        chk("ch0_release_count", npulse, 1);

        // Reset mid-sweep with a pending count on ch2
        i_switch[2] = 1'b0;
        budget = 0;
        while (!(o_busy && m_cnt[2] > 0) && budget < 200) begin
            cycle();
            budget++;
        end
        chk("mid_sweep_found", (budget < 200) ? 1 : 0, 1);
        i_rst = 1'b1;
        cycle();
        chk("mid_sweep_reset", int'({o_switch, o_busy}), 0);
        i_rst = 1'b0;
        run_n(60);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < N; k++) begin
                if ($urandom_range(39) == 0) i_switch[k] = ~i_switch[k];
            end
            if ($urandom_range(99) == 0) i_en = ~i_en;
            if (!i_en && $urandom_range(9) == 0) i_en = 1'b1;
            i_rst = ($urandom_range(499) == 0);
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
